// File: rtl/fetch_prefetch_queue.sv
// -----------------------------------------------------------------------------
// fetch_prefetch_queue
//
// Purpose:
//   Instruction fetch stage with a DEPTH-entry prefetch FIFO. It reads
//   sequential instruction words from the instruction memory port into the
//   FIFO, and decode drains the FIFO through a valid/ready handshake.
//   A redirect (branch/interrupt) flushes the FIFO and restarts fetching at a
//   new PC. A read that is already in flight when the redirect arrives is
//   allowed to finish, and its data is then dropped.
//
// Optional feature (macro FETCH_PREFETCH_BYPASS_EN):
//   When the macro is defined, a word that completes while the FIFO is empty
//   is shown to decode in the same cycle (combinational bypass). If decode
//   takes the word in that cycle, it is not pushed into the FIFO.
//   When the macro is undefined, a fetched word first appears on the outputs
//   in the cycle after its read completes.
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   start, start_pc          begin fetching at start_pc (accepted only in IDLE)
//   redirect_valid/_pc       flush the FIFO and restart at redirect_pc (any state)
//   mem_read_en/_addr        read request to memory, held until completion
//   mem_read_fin/_data       read completion and its data
//   out_valid/out_ready      decode handshake on the FIFO head
//   out_inst/out_pc          head instruction word and its PC
//   out_nxt_pc               out_pc + PC_STEP (wraps)
//   occupancy                number of FIFO entries
//   dbg_state                current FSM state (0 IDLE, 1 FETCH, 2 DRAIN)
//
// Handshakes:
//   Memory: the request rises on mem_read_en. It completes in the cycle where
//   mem_read_en && mem_read_fin. Until that cycle, mem_read_en stays high and
//   mem_read_addr does not change. Decode: a word transfers in the cycle where
//   out_valid && out_ready. While out_valid && !out_ready, out_inst and out_pc
//   hold their values.
// -----------------------------------------------------------------------------
module fetch_prefetch_queue #(
  parameter int XLEN    = 32,
  parameter int ADDR_W  = 32,
  parameter int DEPTH   = 4,
  parameter int PC_STEP = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic [ADDR_W-1:0]        start_pc,
  input  logic                     redirect_valid,
  input  logic [ADDR_W-1:0]        redirect_pc,
  output logic                     mem_read_en,
  output logic [ADDR_W-1:0]        mem_read_addr,
  input  logic                     mem_read_fin,
  input  logic [XLEN-1:0]          mem_read_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [XLEN-1:0]          out_inst,
  output logic [ADDR_W-1:0]        out_pc,
  output logic [ADDR_W-1:0]        out_nxt_pc,
  output logic [$clog2(DEPTH):0]   occupancy,
  output logic [1:0]               dbg_state
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int OCC_W = PTR_W + 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [ADDR_W-1:0]  fetch_pc_q, fetch_pc_d;
  logic               pending_q, pending_d;   // request issued, not yet complete
  logic [ADDR_W-1:0]  req_addr_q, req_addr_d; // address of the pending request
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [OCC_W-1:0]   count_q, count_d;

  logic [XLEN-1:0]    inst_mem_q [DEPTH];
  logic [ADDR_W-1:0]  pc_mem_q   [DEPTH];

  logic               done;
  logic               fifo_valid;
  logic               fifo_full;
  logic               byp;
  logic               push;
  logic               pop;

  // ---------------------------------------------------------------------------
  // Memory request and decode-facing outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    fifo_valid = (count_q != '0);
    fifo_full  = (count_q == OCC_W'(DEPTH));

    // A pending read must keep the request high, even when the FIFO is full.
    // A new read is started only when the FIFO has space at the start of the cycle.
    mem_read_en = 1'b0;
    case (state_q)
      S_FETCH: mem_read_en = pending_q || !fifo_full;
      S_DRAIN: mem_read_en = 1'b1;
      default: mem_read_en = 1'b0;
    endcase

    // While a read is pending, drive its latched address. This keeps the
    // address stable after a redirect has already changed fetch_pc.
    mem_read_addr = pending_q ? req_addr_q : fetch_pc_q;

    done = mem_read_en && mem_read_fin;

`ifdef FETCH_PREFETCH_BYPASS_EN
    byp = (state_q == S_FETCH) && !fifo_valid && done && !redirect_valid;
`else
    byp = 1'b0;
`endif

    out_valid  = fifo_valid || byp;
    out_inst   = byp ? mem_read_data : inst_mem_q[rd_ptr_q];
    out_pc     = byp ? mem_read_addr : pc_mem_q[rd_ptr_q];
    out_nxt_pc = out_pc + ADDR_W'(PC_STEP);
    occupancy  = count_q;
    dbg_state  = state_q;

    // Words from a DRAIN read are never pushed. A redirect cancels the push
    // of a read that completes in the same cycle.
    pop  = fifo_valid && out_ready;
    push = (state_q == S_FETCH) && done && !redirect_valid && !(byp && out_ready);
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    pending_d  = mem_read_en && !mem_read_fin;
    req_addr_d = mem_read_addr;
    wr_ptr_d   = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d   = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    count_d    = count_q + OCC_W'(push) - OCC_W'(pop);

    case (state_q)
      S_IDLE: begin
        if (redirect_valid) begin
          fetch_pc_d = redirect_pc;
          state_d    = S_FETCH;
        end else if (start) begin
          fetch_pc_d = start_pc;
          state_d    = S_FETCH;
        end
      end
      S_FETCH: begin
        if (redirect_valid) begin
          fetch_pc_d = redirect_pc;
          // A read that does not complete this cycle must still finish; its
          // data is dropped in DRAIN.
          state_d    = (mem_read_en && !mem_read_fin) ? S_DRAIN : S_FETCH;
        end else if (done) begin
          fetch_pc_d = fetch_pc_q + ADDR_W'(PC_STEP);
        end
      end
      S_DRAIN: begin
        if (redirect_valid) begin
          fetch_pc_d = redirect_pc;
        end
        if (done) begin
          state_d = S_FETCH;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Flush: this overrides any push or pop computed above.
    if (redirect_valid) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      fetch_pc_q <= '0;
      pending_q  <= 1'b0;
      req_addr_q <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        inst_mem_q[i] <= '0;
        pc_mem_q[i]   <= '0;
      end
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      pending_q  <= pending_d;
      req_addr_q <= req_addr_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      if (push) begin
        inst_mem_q[wr_ptr_q] <= mem_read_data;
        pc_mem_q[wr_ptr_q]   <= mem_read_addr;
      end
    end
  end

endmodule

// File: tb/tb_fetch_prefetch_queue.sv
// -----------------------------------------------------------------------------
// tb_fetch_prefetch_queue
//
// Directed, table-driven bench for fetch_prefetch_queue (default build,
// bypass macro undefined). Each table row gives the inputs for one clock
// cycle and the outputs expected during that cycle. The memory model returns
// addr ^ 32'hDEAD_BEEF, so the expected instruction word follows from the
// expected PC.
// -----------------------------------------------------------------------------
module tb_fetch_prefetch_queue;

  localparam int XLEN   = 32;
  localparam int ADDR_W = 32;
  localparam int DEPTH  = 4;

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic               rst;
  logic               start;
  logic [ADDR_W-1:0]  start_pc;
  logic               redirect_valid;
  logic [ADDR_W-1:0]  redirect_pc;
  logic               mem_read_en;
  logic [ADDR_W-1:0]  mem_read_addr;
  logic               mem_read_fin;
  logic [XLEN-1:0]    mem_read_data;
  logic               out_valid;
  logic               out_ready;
  logic [XLEN-1:0]    out_inst;
  logic [ADDR_W-1:0]  out_pc;
  logic [ADDR_W-1:0]  out_nxt_pc;
  logic [2:0]         occupancy;
  logic [1:0]         dbg_state;

  fetch_prefetch_queue #(
    .XLEN(XLEN), .ADDR_W(ADDR_W), .DEPTH(DEPTH), .PC_STEP(4)
  ) dut (
    .clk(clk), .rst(rst),
    .start(start), .start_pc(start_pc),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .mem_read_en(mem_read_en), .mem_read_addr(mem_read_addr),
    .mem_read_fin(mem_read_fin), .mem_read_data(mem_read_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_inst(out_inst), .out_pc(out_pc), .out_nxt_pc(out_nxt_pc),
    .occupancy(occupancy), .dbg_state(dbg_state)
  );

  // Instruction memory contents, as a function of address
  function automatic logic [XLEN-1:0] mem_word(input logic [ADDR_W-1:0] a);
    return a ^ 32'hDEAD_BEEF;
  endfunction

  assign mem_read_data = mem_word(mem_read_addr);

  // scoreboard
  int checks = 0;
  int passed = 0;

  task automatic check(input string name, input int idx,
                       input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp)
      $display("FAIL %s step %0d: got %h want %h", name, idx, act, exp);
    else
      passed++;
  endtask

  typedef struct {
    logic        chk;
    logic        rst;
    logic        start;
    logic        redir;
    logic        fin;
    logic        ready;
    logic [31:0] pc_in;
    logic        exp_en;
    logic [31:0] exp_addr;
    logic        exp_valid;
    logic [31:0] exp_pc;
    logic [2:0]  exp_occ;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic chk, input logic r, input logic s, input logic rd,
                     input logic f, input logic rdy, input logic [31:0] pc_in,
                     input logic en, input logic [31:0] addr, input logic v,
                     input logic [31:0] pc, input logic [2:0] occ);
    vec_t t;
    t.chk = chk; t.rst = r; t.start = s; t.redir = rd; t.fin = f; t.ready = rdy;
    t.pc_in = pc_in; t.exp_en = en; t.exp_addr = addr; t.exp_valid = v;
    t.exp_pc = pc; t.exp_occ = occ;
    vecs.push_back(t);
  endtask

  task automatic drive_idle();
    rst = 1'b0; start = 1'b0; start_pc = '0; redirect_valid = 1'b0;
    redirect_pc = '0; mem_read_fin = 1'b0; out_ready = 1'b0;
  endtask

  initial begin
    drive_idle();

    //   chk rst st rd fin rdy pc_in          en addr          v  pc            occ
    // reset, then streaming from 0x100 with fin every cycle and ready=1
    add(0, 1, 0, 0, 0, 0, 32'h0,          0, 32'h0,          0, 32'h0,          0);
    add(1, 0, 0, 0, 0, 0, 32'h0,          0, 32'h0,          0, 32'h0,          0);
    add(1, 0, 1, 0, 0, 0, 32'h100,        0, 32'h0,          0, 32'h0,          0);
    add(1, 0, 0, 0, 1, 1, 32'h0,          1, 32'h100,        0, 32'h0,          0);
    add(1, 0, 0, 0, 1, 1, 32'h0,          1, 32'h104,        1, 32'h100,        1);
    add(1, 0, 0, 0, 1, 1, 32'h0,          1, 32'h108,        1, 32'h104,        1);
    add(1, 0, 0, 0, 0, 1, 32'h0,          1, 32'h10C,        1, 32'h108,        1);
    add(1, 0, 0, 0, 0, 0, 32'h0,          1, 32'h10C,        0, 32'h0,          0);
    // reset, fill to DEPTH with ready=0 starting at 0x0
    add(1, 1, 0, 0, 0, 0, 32'h0,          1, 32'h10C,        0, 32'h0,          0);
    add(1, 0, 1, 0, 0, 0, 32'h0,          0, 32'h0,          0, 32'h0,          0);
    add(1, 0, 0, 0, 1, 0, 32'h0,          1, 32'h0,          0, 32'h0,          0);
    add(1, 0, 0, 0, 1, 0, 32'h0,          1, 32'h4,          1, 32'h0,          1);
    add(1, 0, 0, 0, 1, 0, 32'h0,          1, 32'h8,          1, 32'h0,          2);
    add(1, 0, 0, 0, 1, 0, 32'h0,          1, 32'hC,          1, 32'h0,          3);
    add(1, 0, 0, 0, 1, 0, 32'h0,          0, 32'h0,          1, 32'h0,          4);
    // full with a pop this cycle: still no new request
    add(1, 0, 0, 0, 1, 1, 32'h0,          0, 32'h0,          1, 32'h0,          4);
    add(1, 0, 0, 0, 0, 0, 32'h0,          1, 32'h10,         1, 32'h4,          3);
    add(1, 0, 0, 0, 1, 1, 32'h0,          1, 32'h10,         1, 32'h4,          3);
    add(1, 0, 0, 0, 0, 1, 32'h0,          1, 32'h14,         1, 32'h8,          3);
    // redirect together with fin and a pop at occupancy 2
    add(1, 0, 0, 1, 1, 1, 32'h20,         1, 32'h14,         1, 32'hC,          2);
    // redirect in cycle 1 of read 0x20, which completes in cycle 3
    add(1, 0, 0, 1, 0, 0, 32'h400,        1, 32'h20,         0, 32'h0,          0);
    add(1, 0, 0, 0, 0, 0, 32'h0,          1, 32'h20,         0, 32'h0,          0);
    add(1, 0, 0, 0, 1, 0, 32'h0,          1, 32'h20,         0, 32'h0,          0);
    add(1, 0, 0, 0, 1, 0, 32'h0,          1, 32'h400,        0, 32'h0,          0);
    add(1, 0, 0, 0, 1, 0, 32'h0,          1, 32'h404,        1, 32'h400,        1);
    add(1, 0, 0, 0, 1, 0, 32'h0,          1, 32'h408,        1, 32'h400,        2);
    // reset during a transaction at occupancy 3; start is needed to resume
    add(1, 1, 0, 0, 0, 0, 32'h0,          1, 32'h40C,        1, 32'h400,        3);
    add(1, 0, 0, 0, 0, 0, 32'h0,          0, 32'h0,          0, 32'h0,          0);
    add(1, 0, 1, 0, 0, 0, 32'hFFFF_FFFC,  0, 32'h0,          0, 32'h0,          0);
    // PC wraps
    add(1, 0, 0, 0, 1, 0, 32'h0,          1, 32'hFFFF_FFFC,  0, 32'h0,          0);
    add(1, 0, 0, 0, 0, 1, 32'h0,          1, 32'h0,          1, 32'hFFFF_FFFC,  1);
    add(1, 0, 0, 0, 0, 0, 32'h0,          1, 32'h0,          0, 32'h0,          0);

    foreach (vecs[i]) begin
      @(negedge clk);
      rst            = vecs[i].rst;
      start          = vecs[i].start;
      start_pc       = vecs[i].pc_in;
      redirect_valid = vecs[i].redir;
      redirect_pc    = vecs[i].pc_in;
      mem_read_fin   = vecs[i].fin;
      out_ready      = vecs[i].ready;
      #1;
      if (vecs[i].chk) begin
        check("mem_read_en", i, 32'(mem_read_en), 32'(vecs[i].exp_en));
        if (vecs[i].exp_en)
          check("mem_read_addr", i, mem_read_addr, vecs[i].exp_addr);
        check("out_valid", i, 32'(out_valid), 32'(vecs[i].exp_valid));
        if (vecs[i].exp_valid) begin
          check("out_pc", i, out_pc, vecs[i].exp_pc);
          check("out_inst", i, out_inst, mem_word(vecs[i].exp_pc));
          check("out_nxt_pc", i, out_nxt_pc, vecs[i].exp_pc + 32'd4);
        end
        check("occupancy", i, 32'(occupancy), 32'(vecs[i].exp_occ));
      end
    end

    // Hand-written: redirect wins over start in IDLE, then the head stays
    // stable while decode stalls.
    @(negedge clk);
    drive_idle();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0; start = 1'b1; start_pc = 32'h200;
    redirect_valid = 1'b1; redirect_pc = 32'h300;
    #1 check("idle_no_req", 100, 32'(mem_read_en), 32'd0);
    @(negedge clk);
    start = 1'b0; redirect_valid = 1'b0; mem_read_fin = 1'b1;
    #1 check("prio_addr", 101, mem_read_addr, 32'h300);
    @(negedge clk);
    mem_read_fin = 1'b0; out_ready = 1'b0;
    begin
      int n = 0;
      while (!out_valid && n < 8) begin
        @(negedge clk);
        n++;
      end
    end
    #1 check("valid_wait", 102, 32'(out_valid), 32'd1);
    for (int k = 0; k < 3; k++) begin
      check("stall_pc", 103 + k, out_pc, 32'h300);
      check("stall_inst", 103 + k, out_inst, mem_word(32'h300));
      @(negedge clk);
      #1;
    end
    check("stall_pending_addr", 106, mem_read_addr, 32'h304);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
